uart_rx_fifo: RTL and testbench

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each received byte on the receiver's completion strobe and stores it in a synchronous FIFO. Bytes are presented to the host/bus side through a valid/ready handshake. The block also reports fill level and a sticky overflow flag so that software can detect lost bytes.

---
 rtl/uart_rx_fifo.sv | 109 ++++++++++
 tb/tb_uart_rx_fifo.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO between the UART receiver and the host, with fill level and sticky overflow.
// Optional UART_RX_FIFO_ERR_TAG_EN stores the frame-error bit with each byte; otherwise errored bytes are dropped.
module uart_rx_fifo #(
   parameter int DATA_WIDTH  = 8,
   parameter int DEPTH       = 16,
   parameter int AFULL_LEVEL = DEPTH - 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DATA_WIDTH-1:0]      rx_data,
   input  logic                       rx_valid,
   input  logic                       rx_frame_error,
   output logic [DATA_WIDTH-1:0]      m_data,
   output logic                       m_frame_error,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       almost_full,
   output logic                       overflow,
   input  logic                       clear_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] PONE      = PW'(1);
   localparam logic [PW-1:0] AFULL_CNT = PW'(AFULL_LEVEL);
`ifdef UART_RX_FIFO_ERR_TAG_EN
   localparam int MW = DATA_WIDTH + 1;
`else
   localparam int MW = DATA_WIDTH;
`endif

   logic [MW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_wrPtr;
   logic [PW-1:0] r_rdPtr;
   logic [PW-1:0] r_count;
   logic          r_overflow;

   logic          w_empty;
   logic          w_full;
   logic          w_pushReq;
   logic          w_push;
   logic          w_pop;
   logic          w_drop;
   logic [MW-1:0] w_wrWord;
   logic [MW-1:0] w_head;

   assign w_empty = (r_wrPtr == r_rdPtr);
   assign w_full  = (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]) && (r_wrPtr[AW] != r_rdPtr[AW]);

`ifdef UART_RX_FIFO_ERR_TAG_EN
   assign w_pushReq = rx_valid;
   assign w_wrWord  = {rx_frame_error, rx_data};
`else
   assign w_pushReq = rx_valid & ~rx_frame_error;
   assign w_wrWord  = rx_data;
`endif

   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign w_pop  = ~w_empty & m_ready;
   assign w_push = w_pushReq & (~w_full | w_pop);
   assign w_drop = w_pushReq & w_full & ~w_pop;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr[AW-1:0]] <= w_wrWord;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PONE;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + PONE;
            2'b01:   r_count <= r_count - PONE;
            default: r_count <= r_count;
         endcase
         // A new drop outranks a simultaneous clear so no lost byte goes unreported.
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (clear_overflow) begin
            r_overflow <= 1'b0;
         end
      end
   end

   assign w_head = r_mem[r_rdPtr[AW-1:0]];
   assign m_data = w_head[DATA_WIDTH-1:0];
`ifdef UART_RX_FIFO_ERR_TAG_EN
   assign m_frame_error = w_head[DATA_WIDTH];
`else
   assign m_frame_error = 1'b0;
`endif
   assign m_valid     = ~w_empty;
   assign count       = r_count;
   assign almost_full = (r_count >= AFULL_CNT);
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a queue of {frame_error, byte} holds what the consumer must see next.
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_error;
   logic [7:0] m_data;
   logic       m_frame_error;
   logic       m_valid;
   logic       m_ready;
   logic [4:0] count;
   logic       almost_full;
   logic       overflow;
   logic       clear_overflow;

   int checks = 0;
   int errors = 0;
   logic [8:0] expQ[$];
   logic [8:0] head;

   uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_LEVEL(14)) dut (
      .clk(clk), .reset(reset),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_error(rx_frame_error),
      .m_data(m_data), .m_frame_error(m_frame_error), .m_valid(m_valid), .m_ready(m_ready),
      .count(count), .almost_full(almost_full), .overflow(overflow),
      .clear_overflow(clear_overflow)
   );

   always #5 clk = ~clk;

   // Advance one edge and settle just after it so inputs change and outputs are read away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // One-cycle receiver strobe; accepted bytes are recorded in the scoreboard by the caller.
   task automatic applyStimulus(input logic [7:0] data, input logic fe, input logic ready);
      rx_data        = data;
      rx_frame_error = fe;
      rx_valid       = 1'b1;
      m_ready        = ready;
      tick();
      rx_valid       = 1'b0;
      rx_frame_error = 1'b0;
      m_ready        = 1'b0;
   endtask

   // Compare the head against the scoreboard, then consume it with one m_ready cycle.
   task automatic popAndCheck(input string tag);
      if (expQ.size() == 0) begin
         checkOutput({tag, "_sb_empty"}, 16'd1, 16'd0);
      end else begin
         head = expQ.pop_front();
         checkOutput({tag, "_valid"}, {15'd0, m_valid}, 16'd1);
         checkOutput({tag, "_data"}, {8'd0, m_data}, {8'd0, head[7:0]});
         checkOutput({tag, "_fe"}, {15'd0, m_frame_error}, {15'd0, head[8]});
         m_ready = 1'b1;
         tick();
         m_ready = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1; rx_data = '0; rx_valid = 1'b0; rx_frame_error = 1'b0;
      m_ready = 1'b0; clear_overflow = 1'b0;
      tick(); tick();
      reset = 1'b0;
      checkOutput("rst_count", {11'd0, count}, 16'd0);
      checkOutput("rst_valid", {15'd0, m_valid}, 16'd0);
      checkOutput("rst_ovf", {15'd0, overflow}, 16'd0);
      checkOutput("rst_afull", {15'd0, almost_full}, 16'd0);

      applyStimulus(8'h55, 1'b0, 1'b0);
      expQ.push_back({1'b0, 8'h55});
      checkOutput("single_count", {11'd0, count}, 16'd1);
      popAndCheck("single");
      checkOutput("single_empty_valid", {15'd0, m_valid}, 16'd0);
      checkOutput("single_empty_count", {11'd0, count}, 16'd0);

      for (int i = 1; i <= 16; i++) begin
         applyStimulus(8'(i), 1'b0, 1'b0);
         expQ.push_back({1'b0, 8'(i)});
         checkOutput($sformatf("fill_count_%0d", i), {11'd0, count}, 16'(i));
         checkOutput($sformatf("fill_afull_%0d", i), {15'd0, almost_full}, {15'd0, (i >= 14)});
      end

      applyStimulus(8'hAA, 1'b0, 1'b0);
      checkOutput("ovf_set", {15'd0, overflow}, 16'd1);
      checkOutput("ovf_count", {11'd0, count}, 16'd16);
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      checkOutput("ovf_clear", {15'd0, overflow}, 16'd0);

      head = expQ.pop_front();
      checkOutput("fullpp_head", {8'd0, m_data}, {8'd0, head[7:0]});
      applyStimulus(8'hBB, 1'b0, 1'b1);
      expQ.push_back({1'b0, 8'hBB});
      checkOutput("fullpp_count", {11'd0, count}, 16'd16);
      checkOutput("fullpp_ovf", {15'd0, overflow}, 16'd0);

      for (int n = 0; n < 40 && expQ.size() > 0; n++) begin
         popAndCheck($sformatf("drain_%0d", n));
      end
      checkOutput("drain_left", 16'(expQ.size()), 16'd0);
      checkOutput("drain_count", {11'd0, count}, 16'd0);
      checkOutput("drain_valid", {15'd0, m_valid}, 16'd0);

      applyStimulus(8'h3C, 1'b1, 1'b0);
`ifdef UART_RX_FIFO_ERR_TAG_EN
      expQ.push_back({1'b1, 8'h3C});
      popAndCheck("fe_tag");
`else
      checkOutput("fe_drop_valid", {15'd0, m_valid}, 16'd0);
      checkOutput("fe_drop_count", {11'd0, count}, 16'd0);
      checkOutput("fe_drop_ovf", {15'd0, overflow}, 16'd0);
`endif

      applyStimulus(8'h11, 1'b0, 1'b0);
      applyStimulus(8'h22, 1'b0, 1'b0);
      applyStimulus(8'h33, 1'b0, 1'b0);
      expQ.push_back({1'b0, 8'h11});
      expQ.push_back({1'b0, 8'h22});
      expQ.push_back({1'b0, 8'h33});
      popAndCheck("middrain");
      reset = 1'b1;
      tick();
      reset = 1'b0;
      expQ.delete();
      checkOutput("midrst_count", {11'd0, count}, 16'd0);
      checkOutput("midrst_valid", {15'd0, m_valid}, 16'd0);
      checkOutput("midrst_ovf", {15'd0, overflow}, 16'd0);

      applyStimulus(8'h7E, 1'b0, 1'b0);
      expQ.push_back({1'b0, 8'h7E});
      checkOutput("post_rst_count", {11'd0, count}, 16'd1);
      popAndCheck("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
